// File: rtl/uart_tx_arbiter_if.sv
// Purpose: bundles the requester handshake and the uart_module transmit-side signals of uart_tx_arbiter.
// Latency: no logic here; it carries wires only.
// Backpressure: requesters hold req_valid until they see their req_ready bit; uart_tx_busy paces frames.
// Ports: master = arbiter view (drives req_ready, grant_id, uart_tx_*, arb_busy, err_timeout);
//        slave  = requesters/UART view (drives req_valid, req_data, uart_tx_busy).
interface uart_tx_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = 32
);
   localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ*DATA_W-1:0] req_data;
   logic [NUM_REQ-1:0]        req_ready;
   logic [ID_W-1:0]           grant_id;
   logic [DATA_W-1:0]         uart_tx_reg;
   logic                      uart_tx_en;
   logic                      uart_tx_busy;
   logic                      arb_busy;
   logic                      err_timeout;

   modport master (
      input  req_valid, req_data, uart_tx_busy,
      output req_ready, grant_id, uart_tx_reg, uart_tx_en, arb_busy, err_timeout
   );

   modport slave (
      output req_valid, req_data, uart_tx_busy,
      input  req_ready, grant_id, uart_tx_reg, uart_tx_en, arb_busy, err_timeout
   );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Purpose: round-robin share of one uart_module transmitter among NUM_REQ requesters, with idle gap and start watchdog.
// Latency: word accepted in cycle T, uart_tx_en in T+1; next acceptance no earlier than T+4+GAP_CYCLES.
// Backpressure: one word accepted per frame, only in IDLE; req_ready is a one-cycle one-hot strobe.
// Ports: sys_clk, sys_rst (async, active-high); bus (uart_tx_arbiter_if.master) carries
//        req_valid/req_data/req_ready, grant_id, uart_tx_reg/uart_tx_en/uart_tx_busy, arb_busy, err_timeout.
module uart_tx_arbiter #(
   parameter int NUM_REQ       = 4,
   parameter int DATA_W        = 32,
   parameter int GAP_CYCLES    = 16,
   parameter int START_TIMEOUT = 64
) (
   input  logic               sys_clk,
   input  logic               sys_rst,
   uart_tx_arbiter_if.master  bus
);
   localparam int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   // One counter serves both the start watchdog and the gap, so size it for the larger.
   localparam int CNT_MAX = (START_TIMEOUT > GAP_CYCLES) ? START_TIMEOUT : GAP_CYCLES;
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX + 1) : 1;
   localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'((START_TIMEOUT > 0) ? START_TIMEOUT - 1 : 0);
   // GAP_CYCLES of 0 and 1 both give a single GAP cycle.
   localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LAUNCH,
      S_WAIT_START,
      S_WAIT_DONE,
      S_GAP
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
   logic [ID_W-1:0]    grant_id_q, grant_id_d;
   logic [DATA_W-1:0]  tx_reg_q, tx_reg_d;

   logic [DATA_W-1:0]  words [NUM_REQ];
   logic [ID_W-1:0]    winner;
   logic               found;
   logic [ID_W:0]      idx_sum;
   logic [NUM_REQ-1:0] req_ready_c;
   logic               tx_en_c;
   logic               err_c;

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_words
      assign words[g] = bus.req_data[g*DATA_W +: DATA_W];
   end

   // Scan from the pointer upward, wrapping, and take the first valid requester.
   always_comb begin
      found   = 1'b0;
      winner  = '0;
      idx_sum = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         idx_sum = {1'b0, rr_ptr_q} + (ID_W+1)'(i);
         if (idx_sum >= (ID_W+1)'(NUM_REQ)) begin
            idx_sum = idx_sum - (ID_W+1)'(NUM_REQ);
         end
         if (!found && bus.req_valid[idx_sum[ID_W-1:0]]) begin
            found  = 1'b1;
            winner = idx_sum[ID_W-1:0];
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      rr_ptr_d    = rr_ptr_q;
      grant_id_d  = grant_id_q;
      tx_reg_d    = tx_reg_q;
      req_ready_c = '0;
      tx_en_c     = 1'b0;
      err_c       = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (found) begin
               req_ready_c = NUM_REQ'(1) << winner;
               tx_reg_d    = words[winner];
               grant_id_d  = winner;
               rr_ptr_d    = (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + ID_W'(1);
               state_d     = S_LAUNCH;
            end
         end
         S_LAUNCH: begin
            tx_en_c = 1'b1;
            cnt_d   = '0;
            state_d = S_WAIT_START;
         end
         S_WAIT_START: begin
            // A busy already high here (stale from a previous frame) counts as the start.
            if (bus.uart_tx_busy) begin
               state_d = S_WAIT_DONE;
            end else if (cnt_q == TO_LAST) begin
               err_c   = 1'b1;
               cnt_d   = '0;
               state_d = S_GAP;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_WAIT_DONE: begin
            if (!bus.uart_tx_busy) begin
               cnt_d   = '0;
               state_d = S_GAP;
            end
         end
         S_GAP: begin
            if (cnt_q == GAP_LAST) begin
               cnt_d   = '0;
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         rr_ptr_q   <= '0;
         grant_id_q <= '0;
         tx_reg_q   <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         rr_ptr_q   <= rr_ptr_d;
         grant_id_q <= grant_id_d;
         tx_reg_q   <= tx_reg_d;
      end
   end

   // req_ready is combinational off req_valid, so gate it to stay quiet while reset is held.
   assign bus.req_ready   = sys_rst ? '0 : req_ready_c;
   assign bus.grant_id    = grant_id_q;
   assign bus.uart_tx_reg = tx_reg_q;
   assign bus.uart_tx_en  = tx_en_c;
   assign bus.arb_busy    = (state_q != S_IDLE);
   assign bus.err_timeout = err_c;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;
   logic sys_clk = 1'b0;
   logic sys_rst;
   int   tests = 0;
   int   fails = 0;

   always #5 sys_clk = ~sys_clk;

   uart_tx_arbiter_if #(.NUM_REQ(4), .DATA_W(32)) ifa ();
   uart_tx_arbiter_if #(.NUM_REQ(4), .DATA_W(32)) ifb ();

   uart_tx_arbiter #(.NUM_REQ(4), .DATA_W(32), .GAP_CYCLES(16), .START_TIMEOUT(64)) dut_a (
      .sys_clk (sys_clk),
      .sys_rst (sys_rst),
      .bus     (ifa)
   );

   uart_tx_arbiter #(.NUM_REQ(4), .DATA_W(32), .GAP_CYCLES(0), .START_TIMEOUT(8)) dut_b (
      .sys_clk (sys_clk),
      .sys_rst (sys_rst),
      .bus     (ifb)
   );

   task automatic step();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One full frame on dut_a (GAP_CYCLES=16), entered in the IDLE cycle where acceptance happens.
   // Busy stays low for dly WAIT_START cycles, then high for len cycles (len >= 1).
   task automatic frame(input int id, input logic [31:0] word, input int dly, input int len);
      logic [3:0] oh;
      oh = 4'b0001 << id;
      #1;
      chk("accept_ready", 64'(ifa.req_ready), 64'(oh));
      chk("accept_idle", 64'(ifa.arb_busy), 64'd0);
      step();
      chk("launch_en", 64'(ifa.uart_tx_en), 64'd1);
      chk("launch_reg", 64'(ifa.uart_tx_reg), 64'(word));
      chk("launch_gid", 64'(ifa.grant_id), 64'(id));
      chk("launch_ready0", 64'(ifa.req_ready), 64'd0);
      step();
      chk("wait_en0", 64'(ifa.uart_tx_en), 64'd0);
      repeat (dly) step();
      ifa.uart_tx_busy = 1'b1;
      repeat (len) step();
      ifa.uart_tx_busy = 1'b0;
      step();
      repeat (15) step();
      chk("gap_last_busy", 64'(ifa.arb_busy), 64'd1);
      chk("gap_reg_hold", 64'(ifa.uart_tx_reg), 64'(word));
      step();
      chk("gap_end_idle", 64'(ifa.arb_busy), 64'd0);
   endtask

   initial begin
      sys_rst          = 1'b1;
      ifa.uart_tx_busy = 1'b0;
      ifa.req_valid    = 4'b1111;
      ifa.req_data     = {32'hA0A0A0A3, 32'hA0A0A0A2, 32'hA0A0A0A1, 32'hA0A0A0A0};
      ifb.uart_tx_busy = 1'b0;
      ifb.req_valid    = 4'b0000;
      ifb.req_data     = '0;

      // Reset state, with all requesters already valid.
      repeat (2) step();
      chk("rst_ready", 64'(ifa.req_ready), 64'd0);
      chk("rst_gid", 64'(ifa.grant_id), 64'd0);
      chk("rst_reg", 64'(ifa.uart_tx_reg), 64'd0);
      chk("rst_en", 64'(ifa.uart_tx_en), 64'd0);
      chk("rst_busy", 64'(ifa.arb_busy), 64'd0);
      chk("rst_err", 64'(ifa.err_timeout), 64'd0);
      chk("rst_b_busy", 64'(ifb.arb_busy), 64'd0);
      sys_rst = 1'b0;

      // All four valid: grants rotate 0,1,2,3,0.
      frame(0, 32'hA0A0A0A0, 0, 1);
      frame(1, 32'hA0A0A0A1, 2, 3);
      frame(2, 32'hA0A0A0A2, 1, 5);
      frame(3, 32'hA0A0A0A3, 3, 2);
      frame(0, 32'hA0A0A0A0, 0, 8);
      ifa.req_valid = 4'b0000;
      #1;
      chk("drop_ready0", 64'(ifa.req_ready), 64'd0);

      // Only req 2, minimum-latency frame: next acceptance window opens at T+20.
      step();
      ifa.req_valid          = 4'b0100;
      ifa.req_data[64 +: 32] = 32'h12345678;
      frame(2, 32'h12345678, 0, 1);
      ifa.req_valid = 4'b0000;

      // UART never raises busy: err_timeout at T+65, GAP, then the next requester is served.
      step();
      ifa.req_valid = 4'b1000;
      #1;
      chk("to_ready", 64'(ifa.req_ready), 64'b1000);
      step();
      chk("to_en", 64'(ifa.uart_tx_en), 64'd1);
      repeat (63) step();
      chk("to_err_early", 64'(ifa.err_timeout), 64'd0);
      step();
      chk("to_err_pulse", 64'(ifa.err_timeout), 64'd1);
      chk("to_err_busy", 64'(ifa.arb_busy), 64'd1);
      step();
      chk("to_err_once", 64'(ifa.err_timeout), 64'd0);
      chk("to_gap_busy", 64'(ifa.arb_busy), 64'd1);
      ifa.req_valid = 4'b1001;
      repeat (15) step();
      chk("to_gap_last", 64'(ifa.arb_busy), 64'd1);
      chk("to_gap_noready", 64'(ifa.req_ready), 64'd0);
      step();
      chk("to_next_ready", 64'(ifa.req_ready), 64'b0001);
      frame(0, 32'hA0A0A0A0, 1, 2);
      #1;
      chk("to_ptr1_ready", 64'(ifa.req_ready), 64'b1000);
      ifa.req_valid = 4'b0000;

      // Req 1 valid; req 0 and new req 1 data appear mid-frame and must be ignored until IDLE.
      step();
      ifa.req_valid = 4'b0010;
      #1;
      chk("mid_ready1", 64'(ifa.req_ready), 64'b0010);
      step();
      chk("mid_reg", 64'(ifa.uart_tx_reg), 64'hA0A0A0A1);
      ifa.req_valid          = 4'b0011;
      ifa.req_data[32 +: 32] = 32'hDEADBEEF;
      #1;
      chk("mid_noready", 64'(ifa.req_ready), 64'd0);
      step();
      ifa.uart_tx_busy = 1'b1;
      step();
      ifa.uart_tx_busy = 1'b0;
      #1;
      chk("mid_reg_hold", 64'(ifa.uart_tx_reg), 64'hA0A0A0A1);
      chk("mid_gid_hold", 64'(ifa.grant_id), 64'd1);
      step();
      repeat (15) step();
      step();
      chk("mid_ptr2_req0", 64'(ifa.req_ready), 64'b0001);
      ifa.req_valid = 4'b0111;
      #1;
      chk("mid_ptr2_req2", 64'(ifa.req_ready), 64'b0100);
      ifa.req_valid = 4'b0011;
      frame(0, 32'hA0A0A0A0, 0, 1);
      frame(1, 32'hDEADBEEF, 0, 1);
      ifa.req_valid = 4'b0000;

      // Reset during WAIT_DONE, then pointer back to 0.
      step();
      ifa.req_valid = 4'b0100;
      #1;
      chk("rw_ready2", 64'(ifa.req_ready), 64'b0100);
      step();
      ifa.uart_tx_busy = 1'b1;
      step();
      step();
      chk("rw_in_frame", 64'(ifa.arb_busy), 64'd1);
      #1;
      sys_rst = 1'b1;
      #1;
      chk("rw_busy0", 64'(ifa.arb_busy), 64'd0);
      chk("rw_ready0", 64'(ifa.req_ready), 64'd0);
      chk("rw_gid0", 64'(ifa.grant_id), 64'd0);
      chk("rw_reg0", 64'(ifa.uart_tx_reg), 64'd0);
      chk("rw_en0", 64'(ifa.uart_tx_en), 64'd0);
      chk("rw_err0", 64'(ifa.err_timeout), 64'd0);
      step();
      sys_rst          = 1'b0;
      ifa.uart_tx_busy = 1'b0;
      ifa.req_valid    = 4'b1001;
      #1;
      chk("rw_ptr0", 64'(ifa.req_ready), 64'b0001);
      ifa.req_valid = 4'b1000;
      frame(3, 32'hA0A0A0A3, 0, 1);
      ifa.req_valid = 4'b0000;

      // GAP_CYCLES=0 instance: back-to-back frames from req 0, then a short start timeout.
      step();
      ifb.req_data[31:0] = 32'h55AA0000;
      ifb.req_valid      = 4'b0001;
      #1;
      chk("g0_ready", 64'(ifb.req_ready), 64'b0001);
      step();
      chk("g0_en", 64'(ifb.uart_tx_en), 64'd1);
      chk("g0_reg", 64'(ifb.uart_tx_reg), 64'h55AA0000);
      ifb.uart_tx_busy = 1'b1;
      step();
      step();
      ifb.uart_tx_busy = 1'b0;
      step();
      chk("g0_gap_busy", 64'(ifb.arb_busy), 64'd1);
      chk("g0_gap_noready", 64'(ifb.req_ready), 64'd0);
      step();
      chk("g0_back2back", 64'(ifb.req_ready), 64'b0001);
      chk("g0_idle", 64'(ifb.arb_busy), 64'd0);
      step();
      chk("g0_en2", 64'(ifb.uart_tx_en), 64'd1);
      repeat (7) step();
      chk("g0_to_early", 64'(ifb.err_timeout), 64'd0);
      step();
      chk("g0_to_pulse", 64'(ifb.err_timeout), 64'd1);
      step();
      chk("g0_to_once", 64'(ifb.err_timeout), 64'd0);
      chk("g0_to_gap", 64'(ifb.arb_busy), 64'd1);
      step();
      chk("g0_to_idle", 64'(ifb.req_ready), 64'b0001);
      ifb.req_valid = 4'b0000;
      #1;
      chk("g0_drop", 64'(ifb.req_ready), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
